// File: rtl/data_mem_ctl.sv
// data_mem_ctl: DEPTH x DATA_W two's-complement data memory behind a
// valid/ready request port. Reads answer one cycle after acceptance; a
// hardware sweep zeroes the array one word per cycle after reset and on
// clr_req. Out-of-range accesses never alias: reads report rsp_err, writes
// are dropped and flagged on wr_err.
module data_mem_ctl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256   // legal range 2 .. 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wr_err,
  input  logic              clr_req,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic signed [DATA_W-1:0] ram [DEPTH];

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;
  logic              rsp_err_nxt;
  logic              wr_err_nxt;

  logic addr_ok_c;
  logic accept_c;

  // Unsigned range check and handshake qualification.
  assign addr_ok_c = ({1'b0, req_addr} < DEPTH_C);
  assign accept_c  = req_valid & (state == ST_RUN);

  // Handshake status decodes directly from the state register.
  assign busy      = (state == ST_CLEAR);
  assign req_ready = (state == ST_RUN);

  // Next-state, sweep counter, RAM write port and response next values.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ram_we        = 1'b0;
    ram_waddr     = cnt;
    ram_wdata     = '0;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = 1'b0;
    wr_err_nxt    = 1'b0;

    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = '0;
        if (cnt == LAST_C) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end

      ST_RUN: begin
        if (accept_c) begin
          if (req_we) begin
            if (addr_ok_c) begin
              ram_we    = 1'b1;
              ram_waddr = req_addr;
              ram_wdata = req_wdata;
            end else begin
              wr_err_nxt = 1'b1;
            end
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = ~addr_ok_c;
            rsp_data_nxt  = addr_ok_c ? ram[req_addr] : '0;
          end
        end
        // A request accepted alongside clr_req still completes above.
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and sweep counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Response and error outputs; reset drops any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      wr_err    <= wr_err_nxt;
    end
  end

  // Single write port shared by the sweep and accepted writes; no reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

endmodule
